// File: rtl/sgd_mac_scheduler_if.sv
// Handshake and datapath-control bundle between the SGD MAC scheduler and
// its environment (datapoint RAM, arithmetic datapath, host control).
interface sgd_mac_scheduler_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_MUL    = 4,
  parameter int GRP_WIDTH  = 2
);
  // host control
  logic                  start;
  logic [3:0]            feat;
  logic [ADDR_WIDTH-1:0] data_points;
  logic [7:0]            epoch;
  logic                  hold;
  // RAM handshake
  logic                  data_valid;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] addr;
  // datapath controls
  logic                  wt_load;
  logic [GRP_WIDTH-1:0]  grp_sel;
  logic [MAX_MUL-1:0]    lane_mask;
  logic                  opb_sel;
  logic                  acc_clr;
  logic                  acc_en;
  logic                  bias_en;
  logic                  err_latch;
  logic                  wt_we;
  logic                  bias_we;
  // status
  logic [7:0]            epoch_cnt;
  logic                  busy;
  logic                  done;

  // scheduler side
  modport master (
    input  start, feat, data_points, epoch, hold, data_valid,
    output rd_req, addr, wt_load, grp_sel, lane_mask, opb_sel, acc_clr,
           acc_en, bias_en, err_latch, wt_we, bias_we, epoch_cnt, busy, done
  );

  // environment side
  modport slave (
    output start, feat, data_points, epoch, hold, data_valid,
    input  rd_req, addr, wt_load, grp_sel, lane_mask, opb_sel, acc_clr,
           acc_en, bias_en, err_latch, wt_we, bias_we, epoch_cnt, busy, done
  );
endinterface

// File: rtl/sgd_mac_scheduler.sv
// Cycle-level sequencer for the SGD linear-regression engine. Per data point:
// fetch, prediction over the feature groups, error latch, weight update over
// the same groups, then advance the point/epoch counters. No arithmetic here.
module sgd_mac_scheduler #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int MAX_MUL      = 4,
  parameter int GRP_WIDTH    = 2
) (
  input  logic                CLK,
  input  logic                RST,
  sgd_mac_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOADW = 3'd1,
    ST_FETCH = 3'd2,
    ST_PRED  = 3'd3,
    ST_ERR   = 3'd4,
    ST_UPD   = 3'd5,
    ST_NEXT  = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  localparam logic [3:0] MAX_FEAT_C = 4'(MAX_FEATURES);

  state_t                state_r;
  logic [3:0]            feat_r;
  logic [ADDR_WIDTH-1:0] dp_r;
  logic [7:0]            epoch_r;
  logic [GRP_WIDTH-1:0]  last_grp_r;
  logic                  rd_req_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [GRP_WIDTH-1:0]  grp_sel_r;
  logic                  opb_sel_r;
  logic                  acc_en_r;
  logic                  bias_en_r;
  logic                  err_latch_r;
  logic                  wt_we_r;
  logic                  bias_we_r;
  logic [7:0]            epoch_cnt_r;
  logic                  busy_r;
  logic                  done_r;

  logic [3:0]            feat_clamp_s;
  logic [GRP_WIDTH-1:0]  last_grp_s;
  logic                  read_hit_s;
  logic                  wt_load_s;
  logic                  acc_clr_s;
  logic [MAX_MUL-1:0]    lane_mask_s;

  // Clamp the requested feature count and derive the index of the last group (ngrp-1, at least group 0).
  always_comb begin
    feat_clamp_s = bus.feat;
    last_grp_s   = '0;
    if (bus.feat > MAX_FEAT_C) begin
      feat_clamp_s = MAX_FEAT_C;
    end else begin
      feat_clamp_s = bus.feat;
    end
    if (feat_clamp_s == 4'd0) begin
      last_grp_s = '0;
    end else begin
      last_grp_s = GRP_WIDTH'((8'(feat_clamp_s) - 8'd1) / 8'(MAX_MUL));
    end
  end

  // Read-completion strobes: data_valid only counts while a request is outstanding.
  always_comb begin
    read_hit_s = rd_req_r & bus.data_valid;
    wt_load_s  = 1'b0;
    acc_clr_s  = 1'b0;
    if (state_r == ST_LOADW) begin
      wt_load_s = read_hit_s;
    end else if (state_r == ST_FETCH) begin
      acc_clr_s = read_hit_s;
    end else begin
      wt_load_s = 1'b0;
      acc_clr_s = 1'b0;
    end
  end

  // Lane i is live when its feature index (1-based) falls within the active feature count.
  always_comb begin
    lane_mask_s = '0;
    if ((state_r == ST_PRED) || (state_r == ST_UPD)) begin
      for (int i = 0; i < MAX_MUL; i++) begin
        if ((8'(grp_sel_r) * 8'(MAX_MUL) + 8'(i) + 8'd1) <= 8'(feat_r)) begin
          lane_mask_s[i] = 1'b1;
        end else begin
          lane_mask_s[i] = 1'b0;
        end
      end
    end else begin
      lane_mask_s = '0;
    end
  end

  // Main sequencer: state plus every registered control output.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= ST_IDLE;
      feat_r      <= 4'd0;
      dp_r        <= '0;
      epoch_r     <= 8'd0;
      last_grp_r  <= '0;
      rd_req_r    <= 1'b0;
      addr_r      <= '0;
      grp_sel_r   <= '0;
      opb_sel_r   <= 1'b0;
      acc_en_r    <= 1'b0;
      bias_en_r   <= 1'b0;
      err_latch_r <= 1'b0;
      wt_we_r     <= 1'b0;
      bias_we_r   <= 1'b0;
      epoch_cnt_r <= 8'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            feat_r      <= feat_clamp_s;
            dp_r        <= bus.data_points;
            epoch_r     <= bus.epoch;
            last_grp_r  <= last_grp_s;
            epoch_cnt_r <= 8'd0;
            addr_r      <= '0;
            rd_req_r    <= 1'b1;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            state_r     <= ST_LOADW;
          end
        end
        ST_LOADW: begin
          if (read_hit_s) begin
            if ((epoch_r == 8'd0) || (dp_r == '0)) begin
              rd_req_r <= 1'b0;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
              addr_r   <= '0;
              state_r  <= ST_DONE;
            end else begin
              rd_req_r <= ~bus.hold;
              addr_r   <= ADDR_WIDTH'(1);
              state_r  <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (rd_req_r) begin
            // An issued request is never withdrawn by hold.
            if (bus.data_valid) begin
              rd_req_r  <= 1'b0;
              grp_sel_r <= '0;
              opb_sel_r <= 1'b0;
              acc_en_r  <= 1'b1;
              bias_en_r <= 1'b1;
              state_r   <= ST_PRED;
            end
          end else begin
            rd_req_r <= ~bus.hold;
          end
        end
        ST_PRED: begin
          bias_en_r <= 1'b0;
          if (grp_sel_r == last_grp_r) begin
            acc_en_r    <= 1'b0;
            err_latch_r <= 1'b1;
            grp_sel_r   <= '0;
            state_r     <= ST_ERR;
          end else begin
            grp_sel_r <= grp_sel_r + GRP_WIDTH'(1);
          end
        end
        ST_ERR: begin
          err_latch_r <= 1'b0;
          wt_we_r     <= 1'b1;
          bias_we_r   <= 1'b1;
          opb_sel_r   <= 1'b1;
          grp_sel_r   <= '0;
          state_r     <= ST_UPD;
        end
        ST_UPD: begin
          bias_we_r <= 1'b0;
          if (grp_sel_r == last_grp_r) begin
            wt_we_r   <= 1'b0;
            opb_sel_r <= 1'b0;
            grp_sel_r <= '0;
            state_r   <= ST_NEXT;
          end else begin
            grp_sel_r <= grp_sel_r + GRP_WIDTH'(1);
          end
        end
        ST_NEXT: begin
          if (addr_r < dp_r) begin
            addr_r   <= addr_r + ADDR_WIDTH'(1);
            rd_req_r <= ~bus.hold;
            state_r  <= ST_FETCH;
          end else begin
            epoch_cnt_r <= epoch_cnt_r + 8'd1;
            if ((epoch_cnt_r + 8'd1) == epoch_r) begin
              addr_r  <= '0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              addr_r   <= ADDR_WIDTH'(1);
              rd_req_r <= ~bus.hold;
              state_r  <= ST_FETCH;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          rd_req_r    <= 1'b0;
          addr_r      <= '0;
          grp_sel_r   <= '0;
          opb_sel_r   <= 1'b0;
          acc_en_r    <= 1'b0;
          bias_en_r   <= 1'b0;
          err_latch_r <= 1'b0;
          wt_we_r     <= 1'b0;
          bias_we_r   <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_req    = rd_req_r;
  assign bus.addr      = addr_r;
  assign bus.wt_load   = wt_load_s;
  assign bus.grp_sel   = grp_sel_r;
  assign bus.lane_mask = lane_mask_s;
  assign bus.opb_sel   = opb_sel_r;
  assign bus.acc_clr   = acc_clr_s;
  assign bus.acc_en    = acc_en_r;
  assign bus.bias_en   = bias_en_r;
  assign bus.err_latch = err_latch_r;
  assign bus.wt_we     = wt_we_r;
  assign bus.bias_we   = bias_we_r;
  assign bus.epoch_cnt = epoch_cnt_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_sgd_mac_scheduler.sv
// Self-checking bench for sgd_mac_scheduler: a config table with hand-derived
// totals, random configs traced cycle-by-cycle against a loop-built schedule,
// and directed sequences for RAM stalls, hold, busy start, and reset.
module tb_sgd_mac_scheduler;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  sgd_mac_scheduler_if #(.ADDR_WIDTH(12), .MAX_MUL(4), .GRP_WIDTH(2)) bus ();

  sgd_mac_scheduler #(
    .ADDR_WIDTH(12), .MAX_FEATURES(15), .MAX_MUL(4), .GRP_WIDTH(2)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic        rd_req;
    logic [11:0] addr;
    logic        wt_load;
    logic [1:0]  grp;
    logic [3:0]  mask;
    logic        opb;
    logic        acc_clr;
    logic        acc_en;
    logic        bias_en;
    logic        err_latch;
    logic        wt_we;
    logic        bias_we;
    logic [7:0]  ep;
    logic        busy;
    logic        done;
  } obs_t;

  typedef struct {
    int         feat;
    int         dp;
    int         ep;
    int         exp_cyc;
    int         exp_pred;
    logic [3:0] exp_mask;
    int         exp_epcnt;
  } row_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc_now = 0;
  obs_t exp_q[$];

  // RAM responder: answers in the request cycle unless a stall is programmed for one address
  int          stall_cnt = 0;
  int          stall_lat = 0;
  logic [11:0] stall_addr = 12'd0;
  always @(posedge CLK) begin
    cyc_now <= cyc_now + 1;
    if (bus.rd_req && !bus.data_valid) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
  end
  assign bus.data_valid = bus.rd_req &&
                          (stall_cnt >= ((bus.addr == stall_addr) ? stall_lat : 0));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.rd_req = bus.rd_req;   o.addr = bus.addr;       o.wt_load = bus.wt_load;
    o.grp = bus.grp_sel;     o.mask = bus.lane_mask;  o.opb = bus.opb_sel;
    o.acc_clr = bus.acc_clr; o.acc_en = bus.acc_en;   o.bias_en = bus.bias_en;
    o.err_latch = bus.err_latch; o.wt_we = bus.wt_we; o.bias_we = bus.bias_we;
    o.ep = bus.epoch_cnt;    o.busy = bus.busy;       o.done = bus.done;
    return o;
  endfunction

  // Features left for group g, clipped to the 4 lanes, as a thermometer mask
  function automatic logic [3:0] mask_of(int f, int g);
    int n;
    n = f - g * 4;
    if (n < 0) n = 0;
    if (n > 4) n = 4;
    return 4'((1 << n) - 1);
  endfunction

  // Expected cycle schedule (zero-wait RAM, hold low) starting at the weight-load cycle
  task automatic build_exp(input int f, input int dp, input int ep);
    obs_t r, base;
    int   ng;
    exp_q.delete();
    ng = (f + 3) / 4;
    if (ng == 0) ng = 1;
    r = '0; r.rd_req = 1'b1; r.wt_load = 1'b1; r.busy = 1'b1;
    exp_q.push_back(r);
    if (ep != 0 && dp != 0) begin
      for (int e = 0; e < ep; e++) begin
        for (int a = 1; a <= dp; a++) begin
          base = '0; base.busy = 1'b1; base.ep = 8'(e); base.addr = 12'(a);
          r = base; r.rd_req = 1'b1; r.acc_clr = 1'b1; exp_q.push_back(r);
          for (int g = 0; g < ng; g++) begin
            r = base; r.grp = 2'(g); r.mask = mask_of(f, g); r.acc_en = 1'b1;
            r.bias_en = (g == 0); exp_q.push_back(r);
          end
          r = base; r.err_latch = 1'b1; exp_q.push_back(r);
          for (int g = 0; g < ng; g++) begin
            r = base; r.grp = 2'(g); r.mask = mask_of(f, g); r.wt_we = 1'b1;
            r.opb = 1'b1; r.bias_we = (g == 0); exp_q.push_back(r);
          end
          r = base; exp_q.push_back(r);
        end
      end
    end
    r = '0; r.done = 1'b1; r.ep = (ep != 0 && dp != 0) ? 8'(ep) : 8'd0;
    exp_q.push_back(r);
  endtask

  task automatic pulse_start(input int f, input int dp, input int ep);
    bus.feat = 4'(f); bus.data_points = 12'(dp); bus.epoch = 8'(ep);
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
  endtask

  // Start a run from IDLE/DONE and compare every cycle with the schedule
  task automatic run_trace(input int f, input int dp, input int ep,
                           output int cyc, output int pred, output logic [3:0] lmask);
    obs_t o;
    build_exp(f, dp, ep);
    cyc = -1; pred = 0; lmask = 4'd0;
    pulse_start(f, dp, ep);
    for (int k = 0; k < exp_q.size(); k++) begin
      o = sample();
      chk($sformatf("trace f%0d d%0d e%0d cyc%0d", f, dp, ep, k), 64'(o), 64'(exp_q[k]));
      if (o.done && cyc < 0) cyc = k;
      if (o.acc_en) begin pred++; lmask = o.mask; end
      @(negedge CLK);
    end
  endtask

  task automatic wait_done(input string nm, input int t0, output int cyc);
    int k = 0;
    while (!bus.done && k < 3000) begin @(negedge CLK); k++; end
    chk({nm, "_timeout"}, 64'(k < 3000), 64'd1);
    cyc = cyc_now - t0;
  endtask

  row_t tbl[7];

  initial begin
    int cyc, pred, t0, k;
    logic [3:0] lmask;
    tbl[0] = '{15, 3, 2, 67, 24, 4'b0111, 2};
    tbl[1] = '{ 0, 2, 1, 11,  2, 4'b0000, 1};
    tbl[2] = '{ 5, 1, 3, 22,  6, 4'b0001, 3};
    tbl[3] = '{ 4, 2, 2, 21,  4, 4'b1111, 2};
    tbl[4] = '{ 8, 0, 3,  1,  0, 4'b0000, 0};
    tbl[5] = '{ 9, 2, 0,  1,  0, 4'b0000, 0};
    tbl[6] = '{12, 1, 1, 10,  3, 4'b1111, 1};

    bus.start = 1'b0; bus.feat = 4'd0; bus.data_points = 12'd0;
    bus.epoch = 8'd0; bus.hold = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_state", 64'(sample()), 64'd0);
    RST = 1'b1;
    @(negedge CLK);

    // table: each row starts from IDLE or the previous row's DONE
    for (int i = 0; i < 7; i++) begin
      run_trace(tbl[i].feat, tbl[i].dp, tbl[i].ep, cyc, pred, lmask);
      chk($sformatf("tbl%0d_cycles_to_done", i), 64'(cyc), 64'(tbl[i].exp_cyc));
      chk($sformatf("tbl%0d_pred_cycles", i), 64'(pred), 64'(tbl[i].exp_pred));
      chk($sformatf("tbl%0d_last_mask", i), 64'(lmask), 64'(tbl[i].exp_mask));
      chk($sformatf("tbl%0d_epoch_cnt", i), 64'(bus.epoch_cnt), 64'(tbl[i].exp_epcnt));
    end

    // random configurations against the schedule model
    for (int i = 0; i < 8; i++) begin
      run_trace($urandom_range(0, 15), $urandom_range(0, 4), $urandom_range(0, 3),
                cyc, pred, lmask);
    end

    // RAM stall: three extra wait cycles on address 2
    stall_addr = 12'd2; stall_lat = 3;
    pulse_start(15, 3, 1);
    t0 = cyc_now;
    k = 0;
    while (!(bus.rd_req && bus.addr == 12'd2) && k < 200) begin @(negedge CLK); k++; end
    chk("stall_reach_addr2", 64'(k < 200), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_wait%0d", i), {61'd0, bus.rd_req, bus.acc_en, bus.acc_clr},
          {61'd0, 1'b1, 1'b0, 1'b0});
      chk($sformatf("stall_addr%0d", i), 64'(bus.addr), 64'd2);
      @(negedge CLK);
    end
    chk("stall_release_clr", {62'd0, bus.rd_req, bus.acc_clr}, {62'd0, 1'b1, 1'b1});
    @(negedge CLK);
    chk("stall_pred_start", {61'd0, bus.acc_en, bus.bias_en, bus.grp_sel == 2'd0},
        {61'd0, 1'b1, 1'b1, 1'b1});
    wait_done("stall", t0, cyc);
    chk("stall_cycles", 64'(cyc), 64'd37);
    stall_lat = 0;
    @(negedge CLK);

    // hold: raised during update of point 1, keeps point 2 unfetched for 5 cycles
    pulse_start(5, 2, 1);
    t0 = cyc_now;
    k = 0;
    while (!(bus.wt_we && bus.bias_we) && k < 200) begin @(negedge CLK); k++; end
    chk("hold_reach_upd", 64'(k < 200), 64'd1);
    bus.hold = 1'b1;
    k = 0;
    while (bus.addr != 12'd2 && k < 200) begin @(negedge CLK); k++; end
    chk("hold_reach_addr2", 64'(k < 200), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold_stall%0d", i), {61'd0, bus.rd_req, bus.acc_en, bus.busy},
          {61'd0, 1'b0, 1'b0, 1'b1});
      if (i == 4) bus.hold = 1'b0;
      @(negedge CLK);
    end
    chk("hold_resume", {50'd0, bus.rd_req, bus.acc_clr, bus.addr}, {50'd0, 1'b1, 1'b1, 12'd2});
    @(negedge CLK);
    chk("hold_resume_pred", {60'd0, bus.lane_mask}, {60'd0, 4'b1111});
    wait_done("hold", t0, cyc);
    chk("hold_cycles", 64'(cyc), 64'd20);
    @(negedge CLK);

    // start while busy is ignored
    pulse_start(4, 2, 1);
    t0 = cyc_now;
    repeat (3) @(negedge CLK);
    pulse_start(15, 3, 3);
    wait_done("busy_start", t0, cyc);
    chk("busy_start_cycles", 64'(cyc), 64'd11);
    chk("busy_start_epoch", 64'(bus.epoch_cnt), 64'd1);
    @(negedge CLK);

    // reset during update group 2, then a clean restart
    pulse_start(15, 3, 2);
    k = 0;
    while (!(bus.wt_we && bus.grp_sel == 2'd2) && k < 200) begin @(negedge CLK); k++; end
    chk("rst_reach_upd2", 64'(k < 200), 64'd1);
    #2 RST = 1'b0;
    #1 chk("rst_mid_outputs", 64'(sample()), 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    run_trace(15, 1, 1, cyc, pred, lmask);
    chk("rst_restart_cycles", 64'(cyc), 64'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sgd_mac_scheduler.md
Name: sgd_mac_scheduler

Overview:
- Cycle-level sequencer for the SGD linear-regression engine's shared multiplier bank (MAX_MUL lanes).
- Each data point runs a prediction phase, then an error latch, then a weight-update phase, over ceil(feat/MAX_MUL) feature groups.
- Issues datapoint RAM reads, tracks data-point and epoch counters, and drives all datapath selects and enables. Holds no arithmetic itself.

Parameters:
ADDR_WIDTH, 12, datapoint RAM address width
MAX_FEATURES, 15, maximum feature count
MAX_MUL, 4, multiplier lanes shared across features
GRP_WIDTH, 2, width of group select (covers ceil((MAX_FEATURES)/MAX_MUL) groups)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begins training when in IDLE or DONE
feat  in  4  active feature count, 0..MAX_FEATURES; sampled at start
data_points  in  ADDR_WIDTH  number of data points; sampled at start
epoch  in  8  number of epochs; sampled at start
hold  in  1  stalls new RAM fetches while high
data_valid  in  1  RAM read data valid
rd_req  out  1  RAM read request, held until data_valid
addr  out  ADDR_WIDTH  RAM address: 0 = initial weights, 1..data_points = samples
wt_load  out  1  datapath loads W[0..15] from the data bus
grp_sel  out  GRP_WIDTH  current feature group, feeding the operand muxes
lane_mask  out  MAX_MUL  lane i is valid iff grp_sel*MAX_MUL+i+1 <= feat
opb_sel  out  1  multiplier B operand: 0 = weight, 1 = scaled error
acc_clr  out  1  clears the error accumulator to Y
acc_en  out  1  accumulator subtracts masked products
bias_en  out  1  accumulator also subtracts W[0] (prediction, group 0 only)
err_latch  out  1  captures error>>>learn_rate
wt_we  out  1  adds masked products to the weights of group grp_sel
bias_we  out  1  W[0] += scaled error
epoch_cnt  out  8  completed epochs
busy  out  1  high in any state except IDLE and DONE
done  out  1  high in DONE

Behaviour:
- Reset (async, RST=0): state IDLE. All outputs 0; addr=0, epoch_cnt=0, grp_sel=0. Reset in any state aborts immediately with no partial writes. Release is synchronous to CLK.
- ngrp = max(1, ceil(feat/MAX_MUL)). This gives feat=0 -> 1, 4 -> 1, 5 -> 2, 15 -> 4. Registered at start.
- IDLE: on start, go to LOADW with addr=0. start is ignored when busy=1.
- LOADW: rd_req=1 at addr 0. The cycle data_valid=1 is sampled: wt_load=1. Then:
  - if epoch==0 or data_points==0, go to DONE;
  - otherwise set addr=1 and go to FETCH.
- FETCH: rd_req=1 while hold=0.
  - hold=1 forces rd_req=0, and the state stays in FETCH.
  - A hold asserted after rd_req is already issued does not withdraw it.
  - When data_valid=1 is sampled: acc_clr=1 and go to PRED with grp_sel=0.
  - RAM data stays stable until the next rd_req.
- PRED: ngrp cycles, grp_sel = 0..ngrp-1. acc_en=1, opb_sel=0, bias_en=1 only when grp_sel==0. Then go to ERR.
- ERR: 1 cycle with err_latch=1. grp_sel returns to 0. Then go to UPD.
- UPD: ngrp cycles, grp_sel = 0..ngrp-1. wt_we=1, opb_sel=1, bias_we=1 only when grp_sel==0. Then go to NEXT.
- NEXT: 1 cycle.
  - If addr < data_points: addr+1, then FETCH.
  - Otherwise epoch_cnt+1. If the new epoch_cnt == epoch, go to DONE; else addr=1, then FETCH.
- DONE: done=1, addr=0, rd_req=0. Stays in DONE until start, which clears epoch_cnt and re-enters LOADW. hold has no effect here.
- Per-point latency with zero-wait RAM and hold=0 is 2*ngrp+3 cycles: FETCH 1, PRED ngrp, ERR 1, UPD ngrp, NEXT 1. feat=15 gives 11 cycles.
- lane_mask is combinational from grp_sel and the registered feat. It is 0 outside PRED and UPD.
- acc_en, wt_we, err_latch, acc_clr, wt_load and bias_* are mutually exclusive with each other. Exception: bias_en with acc_en, and bias_we with wt_we.
- The 12-bit addr counter never wraps past data_points. data_points = 2^ADDR_WIDTH-1 is legal.
- data_valid outside LOADW/FETCH, or while rd_req=0, is ignored.

Test Plan:
- Basic run: feat=15, data_points=3, epoch=2, zero-wait RAM. Expect:
  - LOADW addr 0;
  - addr sequence 1,2,3,1,2,3;
  - 4 PRED + 4 UPD cycles per point, grp_sel 0..3;
  - lane_mask 1111,1111,1111,0111;
  - done rises 66 cycles after the first FETCH, epoch_cnt=2.
- Feature edge cases: feat=0 gives ngrp=1, lane_mask=0000, with bias_en/bias_we still pulsing. feat=5 gives ngrp=2, lane_mask 1111 then 0001, and 7 cycles per point.
- RAM stalls and hold: data_valid delayed 3 cycles at addr 2 keeps rd_req high and addr stable with no acc_en. hold=1 for 5 cycles in FETCH keeps rd_req low, and the sequence resumes unchanged.
- Degenerate config: epoch=0 or data_points=0 goes straight to DONE after the LOADW read, with no PRED cycles. start pulsed while busy is ignored.
- Reset mid-operation: RST low during UPD grp 2 immediately zeroes all outputs and sets state IDLE. A later start restarts from addr 0 with epoch_cnt=0.
- Restart from DONE: a start pulse in DONE clears done and epoch_cnt, re-reads addr 0, and repeats the full sequence identically.
